dm_unit: RTL and testbench
==========================

DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 Parameter DEPTH, default 64, memory size in bytes, power of two, at least 4.
REQ-002 Parameter AW, default 6, address width, equal to log2(DEPTH).
REQ-003 Parameter WAIT_STATES, default 0, extra access cycles, range 0..15.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port req_valid, input, 1, request present.
REQ-007 Port req_ready, output, 1, unit can accept a request.
REQ-008 Port req_we, input, 1, 1 = store, 0 = load.
REQ-009 Port req_addr, input, AW, byte address.
REQ-010 Port req_wdata, input, 32, store data, LSB-aligned.
REQ-011 Port req_type, input, 3, access type: 000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned.
REQ-012 Port resp_valid, output, 1, response present.
REQ-013 Port resp_ready, input, 1, consumer accepts the response.
REQ-014 Port resp_rdata, output, 32, load result.
REQ-015 Port resp_err, output, 1, request rejected with no memory effect.

Function
REQ-016 Storage: DEPTH bytes; little-endian, so the byte at addr holds bits [7:0].
REQ-017 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-018 Accept: req_valid & req_ready at an edge latches we/addr/wdata/type, loads the wait counter with WAIT_STATES, and moves IDLE->WAIT.
REQ-019 WAIT with counter != 0: decrement the counter each edge.
REQ-020 WAIT with counter == 0: perform the access at that edge, load resp_rdata/resp_err, and go to RESP.
REQ-021 Latency: resp_valid rises WAIT_STATES+1 edges after the accept edge.
REQ-022 RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid & resp_ready at an edge, then go to IDLE.
REQ-023 Throughput: at most one transaction outstanding; minimum WAIT_STATES+3 cycles per transaction.
REQ-024 Load extension: byte is sign-extended from bit 7, halfword from bit 15; unsigned types are zero-extended; word is the bytes addr+3..addr.
REQ-025 Store width: word writes 4 bytes; 001/010 write req_wdata[15:0] to 2 bytes; 011/100 write req_wdata[7:0] to 1 byte; upper wdata bits are ignored.
REQ-026 Error conditions: req_type 101..111, halfword with addr[0] = 1, or word with addr[1:0] != 0 sets resp_err = 1.
REQ-027 On error: no byte is written, and resp_rdata = 0.
REQ-028 A legal aligned access never crosses the end of memory, so address wrap-around cannot occur.
REQ-029 A successful access gives resp_err = 0; a store gives resp_rdata = 0.
REQ-030 Request inputs are ignored outside IDLE; changes while busy have no effect.
REQ-031 resp_ready is ignored outside RESP.

Reset
REQ-032 rst = 1 forces, immediately and asynchronously: state IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, all memory bytes 0.
REQ-033 Reset in WAIT or RESP aborts the transaction; a store not yet performed leaves memory all zero.
REQ-034 Reset released between edges: the first accept is possible at the first rising edge with rst = 0.

Verification (DEPTH=64, WAIT_STATES=2 unless noted)
REQ-035 Store word 0x8844_2211 at address 0x08, then load byte at 0x0B -> 0xFFFF_FF88; byte unsigned at 0x0B -> 0x0000_0088; halfword at 0x08 -> 0x0000_2211.
REQ-036 Latency: accept at edge N -> resp_valid = 1 after edge N+3; hold resp_ready = 0 for 4 cycles -> outputs stable; with resp_ready = 1, req_ready = 1 after the next edge.
REQ-037 Misaligned halfword store at 0x05 and word load at 0x0E -> resp_err = 1, rdata 0; a subsequent word load at 0x04 -> 0x0000_0000 (memory unchanged).
REQ-038 req_type 110 -> resp_err = 1; byte store 0x7F to address 0x3F (last byte) -> succeeds, and a byte load reads 0x0000_007F.
REQ-039 Reset asserted mid-WAIT of a store -> outputs reset at once; a subsequent word load of that address -> 0x0000_0000.
REQ-040 WAIT_STATES=0: back-to-back store then load of the same address with resp_ready tied 1 -> the load returns the new data, one transaction every 3 cycles.

Source files
------------

// File: rtl/dm_unit.sv
// Byte-addressed little-endian data memory with a valid/ready request and
// response handshake, configurable wait states and sign/zero-extending loads.
module dm_unit #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [2:0]    req_type,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic            we_reg;
  logic [AW-1:0]   addr_reg;
  logic [31:0]     wdata_reg;
  logic [2:0]      type_reg;
  logic [31:0]     rdata_reg, rdata_next;
  logic            err_reg;

  logic [7:0]      mem_reg [DEPTH];
  logic [DEPTH-1:0] byte_we;
  logic [7:0]      byte_wdata [DEPTH];

  logic            accept;
  logic            do_access;
  logic            access_err;
  logic [2:0]      nbytes;
  logic [7:0]      b0, b1, b2, b3;

  assign accept     = (state_reg == IDLE) && req_valid;
  assign do_access  = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  // Access width and alignment check, decoded from the latched request.
  always_comb begin
    nbytes     = 3'd0;
    access_err = 1'b0;
    case (type_reg)
      3'd0: begin
        nbytes     = 3'd4;
        access_err = (addr_reg[1:0] != 2'b00);
      end
      3'd1, 3'd2: begin
        nbytes     = 3'd2;
        access_err = addr_reg[0];
      end
      3'd3, 3'd4: begin
        nbytes     = 3'd1;
      end
      default: begin
        access_err = 1'b1;
      end
    endcase
  end

  // Per-byte write enable and lane select: byte gi is written when its
  // distance from the base address falls inside the access width.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_byte
      logic [AW-1:0] off;
      assign off            = AW'(gi) - addr_reg;
      assign byte_we[gi]    = do_access && we_reg && !access_err &&
                              ({1'b0, off} < (AW+1)'(nbytes));
      assign byte_wdata[gi] = wdata_reg[{off[1:0], 3'b000} +: 8];
    end
  endgenerate

  assign b0 = mem_reg[addr_reg];
  assign b1 = mem_reg[addr_reg + AW'(1)];
  assign b2 = mem_reg[addr_reg + AW'(2)];
  assign b3 = mem_reg[addr_reg + AW'(3)];

  always_comb begin
    rdata_next = 32'd0;
    if (!we_reg && !access_err) begin
      case (type_reg)
        3'd0:    rdata_next = {b3, b2, b1, b0};
        3'd1:    rdata_next = {{16{b1[7]}}, b1, b0};
        3'd2:    rdata_next = {16'd0, b1, b0};
        3'd3:    rdata_next = {{24{b0[7]}}, b0};
        3'd4:    rdata_next = {24'd0, b0};
        default: rdata_next = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid)            state_next = WAIT;
      WAIT:    if (cnt_reg == 4'd0)      state_next = RESP;
      RESP:    if (resp_ready)           state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      type_reg  <= 3'd0;
    end else if (accept) begin
      cnt_reg   <= 4'(WAIT_STATES);
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      type_reg  <= req_type;
    end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
      cnt_reg   <= cnt_reg - 4'd1;
    end
  end

  // Response registers hold their value through RESP and afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else if (do_access) begin
      rdata_reg <= rdata_next;
      err_reg   <= access_err;
    end
  end

  // Storage lives in flops so the whole array clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (byte_we[i]) begin
          mem_reg[i] <= byte_wdata[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_unit.sv
// Directed scoreboard bench for dm_unit: a WAIT_STATES=2 instance for the
// main function and a WAIT_STATES=0 instance for back-to-back throughput.
module tb_dm_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [5:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic [2:0]  a_req_type;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [5:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic [2:0]  b_req_type;
  logic        b_resp_valid, b_resp_err;
  logic        b_resp_ready = 1'b1;
  logic [31:0] b_resp_rdata;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  dm_unit #(.DEPTH(64), .AW(6), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_type(a_req_type),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dm_unit #(.DEPTH(64), .AW(6), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_type(b_req_type),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut_a; called #1 after an edge with the unit idle.
  task automatic txn(input string tag, input logic we, input logic [5:0] addr,
                     input logic [31:0] wd, input logic [2:0] ty,
                     input logic [31:0] ed, input logic ee, input int hold);
    logic [32:0] exp;
    logic [31:0] held;
    int cyc;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_type  = ty;
    exp_q.push_back({ee, ed});
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom);
    a_req_addr  = 6'($urandom);
    a_req_wdata = $urandom;
    a_req_type  = 3'($urandom);
    chk({tag, "_busy"}, 32'(a_req_ready), 32'd0);
    cyc = 0;
    while (!a_resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd3);
    exp = exp_q.pop_front();
    chk({tag, "_rdata"}, a_resp_rdata, exp[31:0]);
    chk({tag, "_err"}, 32'(a_resp_err), 32'(exp[32]));
    held = a_resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(a_resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, a_resp_rdata, held);
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    chk({tag, "_ready_after"}, 32'(a_req_ready), 32'd1);
    chk({tag, "_valid_after"}, 32'(a_resp_valid), 32'd0);
  endtask

  initial begin
    int acc_cyc[$];
    int resp_cyc[$];
    logic rr;
    logic [32:0] bexp;

    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_type = '0;
    a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_type = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_rdata", a_resp_rdata, 32'd0);
    chk("rst_err", 32'(a_resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then sub-word loads of the same location
    txn("st_w08",  1'b1, 6'h08, 32'h8844_2211, 3'b000, 32'h0000_0000, 1'b0, 0);
    txn("ld_b0b",  1'b0, 6'h0B, 32'h0,         3'b011, 32'hFFFF_FF88, 1'b0, 4);
    txn("ld_bu0b", 1'b0, 6'h0B, 32'h0,         3'b100, 32'h0000_0088, 1'b0, 0);
    txn("ld_h08",  1'b0, 6'h08, 32'h0,         3'b001, 32'h0000_2211, 1'b0, 0);
    txn("ld_w08",  1'b0, 6'h08, 32'h0,         3'b000, 32'h8844_2211, 1'b0, 0);

    // Halfword store ignores upper wdata; signed vs unsigned halfword loads
    txn("st_h20",  1'b1, 6'h20, 32'hABCD_8001, 3'b001, 32'h0000_0000, 1'b0, 0);
    txn("ld_h20",  1'b0, 6'h20, 32'h0,         3'b001, 32'hFFFF_8001, 1'b0, 0);
    txn("ld_hu20", 1'b0, 6'h20, 32'h0,         3'b010, 32'h0000_8001, 1'b0, 0);
    txn("ld_w20",  1'b0, 6'h20, 32'h0,         3'b000, 32'h0000_8001, 1'b0, 0);

    // Errors leave memory untouched
    txn("st_h05_mis", 1'b1, 6'h05, 32'hFFFF_FFFF, 3'b001, 32'h0, 1'b1, 0);
    txn("ld_w0e_mis", 1'b0, 6'h0E, 32'h0,         3'b000, 32'h0, 1'b1, 0);
    txn("ld_w04",     1'b0, 6'h04, 32'h0,         3'b000, 32'h0, 1'b0, 0);
    txn("st_t110",    1'b1, 6'h04, 32'h1234_5678, 3'b110, 32'h0, 1'b1, 0);
    txn("ld_w04_b",   1'b0, 6'h04, 32'h0,         3'b000, 32'h0, 1'b0, 0);

    // Last byte of memory
    txn("st_b3f",  1'b1, 6'h3F, 32'h1234_567F, 3'b011, 32'h0000_0000, 1'b0, 0);
    txn("ld_b3f",  1'b0, 6'h3F, 32'h0,         3'b011, 32'h0000_007F, 1'b0, 0);

    // Reset in the middle of a store's wait phase
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'h10;
    a_req_wdata = 32'hDEAD_BEEF; a_req_type = 3'b000;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(a_req_ready), 32'd1);
    chk("arst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("arst_rdata", a_resp_rdata, 32'd0);
    chk("arst_err", 32'(a_resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn("ld_w10_after_rst", 1'b0, 6'h10, 32'h0, 3'b000, 32'h0, 1'b0, 0);
    txn("ld_w08_after_rst", 1'b0, 6'h08, 32'h0, 3'b000, 32'h0, 1'b0, 0);

    // Zero-wait instance: store then load back-to-back, resp_ready tied high
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 6'h0C;
    b_req_wdata = 32'h1234_5678; b_req_type = 3'b000;
    for (int c = 0; c < 12; c++) begin
      rr = b_req_ready;
      @(posedge clk); #1;
      if (rr && b_req_valid) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 1) begin
          exp_q.push_back({1'b0, 32'h0});
          b_req_we = 1'b0; b_req_wdata = 32'h0;
        end else begin
          exp_q.push_back({1'b0, 32'h1234_5678});
          b_req_valid = 1'b0;
        end
      end
      if (b_resp_valid) begin
        resp_cyc.push_back(c);
        bexp = exp_q.pop_front();
        chk("b2b_rdata", b_resp_rdata, bexp[31:0]);
        chk("b2b_err", 32'(b_resp_err), 32'(bexp[32]));
      end
    end
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    chk("b2b_resps", 32'(resp_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2 && resp_cyc.size() == 2) begin
      chk("b2b_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("b2b_resp_spacing", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
      chk("b2b_first_latency", 32'(resp_cyc[0] - acc_cyc[0]), 32'd1);
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
